gate_stream_evaluator: RTL and testbench

Hardware evaluator for the gate-level netlists our synthesis flow emits. It consumes a stream of topologically ordered primitive-gate records (constants, buffers, inverters, 2-input gates) and evaluates each one into an internal net-value store. Primary inputs are written through a side port, and any net can be queried at any time. The bench uses it to cross-check the synthesized netlist against RTL simulation, and in hardware it serves as the reader at the far end of the netlist writer.

---
 rtl/gate_eval_pkg.sv | 39 +++
 rtl/gate_eval_alu.sv | 38 +++
 rtl/gate_stream_evaluator.sv | 117 +++++++++++
 tb/tb_gate_stream_evaluator.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_eval_pkg.sv
// rtl/gate_eval_pkg.sv - shared types and helpers for the gate stream evaluator
package gate_eval_pkg;

    // Net-id width carried in a gate record; the evaluator's NET_W must match.
    localparam int ID_W = 6;

    typedef enum logic [2:0] {
        OP_GND   = 3'd0,
        OP_VCC   = 3'd1,
        OP_BUF   = 3'd2,
        OP_INV   = 3'd3,
        OP_AND2  = 3'd4,
        OP_OR2   = 3'd5,
        OP_XOR2  = 3'd6,
        OP_NAND2 = 3'd7
    } op_e;

    typedef struct packed {
        op_e            op;
        logic [ID_W-1:0] out_id;
        logic [ID_W-1:0] a_id;
        logic [ID_W-1:0] b_id;
    } gate_rec_t;

    typedef struct packed {
        logic val;
        logic def;
    } net_t;

    // Constants ignore both operands; single-input gates ignore b.
    function automatic logic uses_a(op_e op);
        return (op != OP_GND) && (op != OP_VCC);
    endfunction

    function automatic logic uses_b(op_e op);
        return (op == OP_AND2) || (op == OP_OR2) || (op == OP_XOR2) || (op == OP_NAND2);
    endfunction

endpackage

// File: rtl/gate_eval_alu.sv
// rtl/gate_eval_alu.sv - combinational evaluation of one primitive gate with defined-ness
module gate_eval_alu
    import gate_eval_pkg::*;
(
    input  op_e  op,
    input  net_t a,
    input  net_t b,
    output net_t r
);

    logic fn;
    logic def;

    // Boolean function of the gate, ignoring whether operands are defined
    always_comb begin
        fn = 1'b0;
        case (op)
            OP_GND:   fn = 1'b0;
            OP_VCC:   fn = 1'b1;
            OP_BUF:   fn = a.val;
            OP_INV:   fn = ~a.val;
            OP_AND2:  fn = a.val & b.val;
            OP_OR2:   fn = a.val | b.val;
            OP_XOR2:  fn = a.val ^ b.val;
            OP_NAND2: fn = ~(a.val & b.val);
            default:  fn = 1'b0;
        endcase
    end

    // Result is defined only when every operand the gate reads is defined;
    // an undefined result always carries val = 0.
    always_comb begin
        def   = (~uses_a(op) | a.def) & (~uses_b(op) | b.def);
        r.def = def;
        r.val = def & fn;
    end

endmodule

// File: rtl/gate_stream_evaluator.sv
// rtl/gate_stream_evaluator.sv - streaming evaluator of topologically ordered gate records
module gate_stream_evaluator
    import gate_eval_pkg::*;
#(
    parameter int NET_W = ID_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [NET_W-1:0] in_out_id,
    input  logic [NET_W-1:0] in_a_id,
    input  logic [NET_W-1:0] in_b_id,
    input  logic             pi_we,
    input  logic [NET_W-1:0] pi_id,
    input  logic             pi_val,
    input  logic             clr,
    input  logic [NET_W-1:0] q_id,
    output logic             q_val,
    output logic             q_def,
    output logic             res_valid,
    output logic [NET_W-1:0] res_id,
    output logic             res_val,
    output logic             res_def,
    output logic             err,
    output logic [NET_W-1:0] err_id,
    input  logic             err_clr
);

    localparam int NETS = 2 ** NET_W;

    net_t      store [NETS];
    logic      stg_valid;
    gate_rec_t stg;
    net_t      opa;
    net_t      opb;
    net_t      res;
    logic      eval;
    logic      pi_keep;
    logic      new_err;

    assign in_ready = ~clr;

    // Operands come straight from the store: the previous record's write has
    // already landed, so dependent back-to-back records need no forwarding.
    assign opa = store[stg.a_id];
    assign opb = store[stg.b_id];

    gate_eval_alu u_alu (
        .op (stg.op),
        .a  (opa),
        .b  (opb),
        .r  (res)
    );

    // A clear discards whatever record is sitting in its evaluate cycle.
    assign eval      = stg_valid & ~clr;
    assign res_valid = eval;
    assign res_id    = stg.out_id;
    assign res_val   = eval & res.val;
    assign res_def   = eval & res.def;
    assign new_err   = eval & ~res.def;

    // The gate write takes priority over a primary-input write to the same net.
    assign pi_keep = pi_we & ~clr & ~(eval & (stg.out_id == pi_id));

    assign q_val = store[q_id].val;
    assign q_def = store[q_id].def;

    // Single stage register holding the record to evaluate next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid <= 1'b0;
            stg       <= '0;
        end else begin
            stg_valid <= in_valid & in_ready;
            if (in_valid && in_ready) begin
                stg <= '{op: op_e'(in_op), out_id: in_out_id, a_id: in_a_id, b_id: in_b_id};
            end
        end
    end

    // Net store: gate result and primary-input writes, single-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NETS; i++) begin
                store[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < NETS; i++) begin
                store[i] <= '0;
            end
        end else begin
            if (eval) begin
                store[stg.out_id] <= res;
            end
            if (pi_keep) begin
                store[pi_id] <= '{val: pi_val, def: 1'b1};
            end
        end
    end

    // Sticky error capturing the first undefined operand; a fresh error wins over err_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err    <= 1'b0;
            err_id <= '0;
        end else if (new_err && (!err || err_clr)) begin
            err    <= 1'b1;
            err_id <= opa.def ? stg.b_id : stg.a_id;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gate_stream_evaluator.sv
// tb/tb_gate_stream_evaluator.sv - randomized and directed bench against a behavioural net model
module tb_gate_stream_evaluator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [5:0] in_out_id;
    logic [5:0] in_a_id;
    logic [5:0] in_b_id;
    logic       pi_we;
    logic [5:0] pi_id;
    logic       pi_val;
    logic       clr;
    logic [5:0] q_id;
    logic       q_val;
    logic       q_def;
    logic       res_valid;
    logic [5:0] res_id;
    logic       res_val;
    logic       res_def;
    logic       err;
    logic [5:0] err_id;
    logic       err_clr;

    gate_stream_evaluator #(.NET_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_out_id (in_out_id),
        .in_a_id   (in_a_id),
        .in_b_id   (in_b_id),
        .pi_we     (pi_we),
        .pi_id     (pi_id),
        .pi_val    (pi_val),
        .clr       (clr),
        .q_id      (q_id),
        .q_val     (q_val),
        .q_def     (q_def),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_val   (res_val),
        .res_def   (res_def),
        .err       (err),
        .err_id    (err_id),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: net values, the one pending record, sticky error.
    bit mval [64];
    bit mdef [64];
    bit pv;
    int pop, po, pa, pb;
    bit merr;
    int merr_id;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            mval[i] = 1'b0;
            mdef[i] = 1'b0;
        end
        pv      = 1'b0;
        merr    = 1'b0;
        merr_id = 0;
    endtask

    function automatic void ref_eval(input int op, input int a, input int b, output bit v, output bit d);
        bit x;
        bit y;
        x = mval[a];
        y = mval[b];
        case (op)
            0: begin v = 1'b0;     d = 1'b1; end
            1: begin v = 1'b1;     d = 1'b1; end
            2: begin v = x;        d = mdef[a]; end
            3: begin v = !x;       d = mdef[a]; end
            4: begin v = x && y;   d = mdef[a] && mdef[b]; end
            5: begin v = x || y;   d = mdef[a] && mdef[b]; end
            6: begin v = x ^ y;    d = mdef[a] && mdef[b]; end
            default: begin v = !(x && y); d = mdef[a] && mdef[b]; end
        endcase
        if (!d) v = 1'b0;
    endfunction

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model across the edge.
    task automatic cyc(input bit v, input int op, input int o, input int a, input int b,
                       input bit pwe, input int pid, input bit pval, input bit c, input bit ec,
                       input int qi);
        bit ev, ed, nerr;
        int qq;
        in_valid  = v;
        in_op     = 3'(op);
        in_out_id = 6'(o);
        in_a_id   = 6'(a);
        in_b_id   = 6'(b);
        pi_we     = pwe;
        pi_id     = 6'(pid);
        pi_val    = pval;
        clr       = c;
        err_clr   = ec;
        qq        = (qi < 0) ? int'($urandom_range(0, 63)) : qi;
        q_id      = 6'(qq);
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(!c));
        chk("res_valid", 32'(res_valid), 32'(pv && !c));
        ev = 1'b0;
        ed = 1'b0;
        if (pv) ref_eval(pop, pa, pb, ev, ed);
        if (pv && !c) begin
            chk("res_id", 32'(res_id), 32'(po));
            chk("res_val", 32'(res_val), 32'(ev));
            chk("res_def", 32'(res_def), 32'(ed));
        end
        chk("q_val", 32'(q_val), 32'(mval[qq]));
        chk("q_def", 32'(q_def), 32'(mdef[qq]));
        chk("err", 32'(err), 32'(merr));
        chk("err_id", 32'(err_id), 32'(merr_id));
        nerr = pv && !c && !ed;
        if (nerr && (!merr || ec)) begin
            merr    = 1'b1;
            merr_id = !mdef[pa] ? pa : pb;
        end else if (ec) begin
            merr = 1'b0;
        end
        if (c) begin
            for (int i = 0; i < 64; i++) begin
                mval[i] = 1'b0;
                mdef[i] = 1'b0;
            end
        end else begin
            if (pv) begin
                mval[po] = ev;
                mdef[po] = ed;
            end
            if (pwe && !(pv && po == pid)) begin
                mval[pid] = pval;
                mdef[pid] = 1'b1;
            end
        end
        pv  = v && !c;
        pop = op;
        po  = o;
        pa  = a;
        pb  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic rec(input int op, input int o, input int a, input int b);
        cyc(1'b1, op, o, a, b, 1'b0, 0, 1'b0, 1'b0, 1'b0, -1);
    endtask

    task automatic idle();
        cyc(1'b0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, -1);
    endtask

    task automatic pi(input int id, input bit v);
        cyc(1'b0, 0, 0, 0, 0, 1'b1, id, v, 1'b0, 1'b0, -1);
    endtask

    task automatic expect_q(input string tag, input int id, input bit v, input bit d);
        q_id = 6'(id);
        #1;
        chk({tag, "_val"}, 32'(q_val), 32'(v));
        chk({tag, "_def"}, 32'(q_def), 32'(d));
    endtask

    task automatic chain();
        rec(4, 3, 1, 2);
        rec(2, 4, 3, 0);
        rec(1, 5, 0, 0);
        rec(4, 6, 4, 5);
        rec(4, 7, 6, 5);
        rec(2, 8, 7, 0);
        idle();
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_op = '0; in_out_id = '0; in_a_id = '0; in_b_id = '0;
        pi_we = 1'b0; pi_id = '0; pi_val = 1'b0; clr = 1'b0; q_id = '0; err_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_res_val", 32'(res_val), 32'd0);
        chk("rst_res_def", 32'(res_def), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_id", 32'(err_id), 32'd0);
        for (int i = 0; i < 64; i++) begin
            cyc(1'b0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, i);
        end

        // Dependent chain with B = 1, then B = 0.
        pi(1, 1'b1);
        pi(2, 1'b1);
        chain();
        expect_q("chain_b1", 8, 1'b1, 1'b1);
        pi(2, 1'b0);
        chain();
        expect_q("chain_b0", 8, 1'b0, 1'b1);

        // Undefined operand capture, sticky first error, clear racing a new error.
        rec(4, 9, 10, 1);
        idle();
        chk("err_set", 32'(err), 32'd1);
        chk("err_id_first", 32'(err_id), 32'd10);
        rec(4, 9, 11, 1);
        idle();
        chk("err_id_sticky", 32'(err_id), 32'd10);
        rec(4, 9, 1, 12);
        cyc(1'b0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, -1);
        chk("err_clr_race", 32'(err), 32'd1);
        chk("err_id_race", 32'(err_id), 32'd12);

        // Gate write beats a same-edge primary-input write.
        rec(0, 12, 0, 0);
        cyc(1'b0, 0, 0, 0, 0, 1'b1, 12, 1'b1, 1'b0, 1'b0, -1);
        expect_q("conflict", 12, 1'b0, 1'b1);

        // Clear during an evaluate cycle.
        rec(1, 20, 0, 0);
        cyc(1'b1, 1, 21, 0, 0, 1'b1, 22, 1'b1, 1'b1, 1'b0, -1);
        expect_q("clr_20", 20, 1'b0, 1'b0);
        chk("clr_keeps_err", 32'(err), 32'd1);
        for (int i = 0; i < 64; i++) begin
            cyc(1'b0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, i);
        end

        // Randomized stream with a mid-stream reset pulse.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                rec(1, 30, 0, 0);
                rst_n = 1'b0;
                #1;
                chk("rst_mid_res_valid", 32'(res_valid), 32'd0);
                chk("rst_mid_err", 32'(err), 32'd0);
                model_reset();
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                expect_q("rst_mid_30", 30, 1'b0, 1'b0);
            end
            cyc($urandom_range(0, 9) < 8, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                $urandom_range(0, 9) < 3, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 24) == 0, $urandom_range(0, 9) == 0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
